// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the GPU DMA reader and writer: FSM codes, error codes, AXI constants.
package painterengine_gpu_dma_pkg;

  typedef enum logic [2:0] {
    ST_ROUTING     = 3'd0,
    ST_PARAM_CHECK = 3'd1,
    ST_CALC        = 3'd2,
    ST_ADDR        = 3'd3,
    ST_DATA        = 3'd4,
    ST_DONE        = 3'd6,
    ST_ERROR       = 3'd7
  } dma_state_t;

  typedef enum logic [2:0] {
    ERR_OK           = 3'd0,
    ERR_ROUTER       = 3'd1,
    ERR_ADDRESS      = 3'd2,
    ERR_AR_TIMEOUT   = 3'd3,
    ERR_DATA_TIMEOUT = 3'd4,
    ERR_RESP         = 3'd5,
    ERR_LAST         = 3'd6
  } dma_err_t;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [3:0]  AXI_CACHE_MOD  = 4'b0010;
  localparam logic [15:0] TIMEOUT_LIMIT  = 16'hFFFF;

  // True when exactly one of the four router bits is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Channel index of a one-hot router value (only meaningful when one-hot).
  function automatic logic [1:0] onehot_to_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Burst length for the next AXI burst: stays inside the current 1 KB page and never
// exceeds the words still to transfer. Result is always 1..256.
module painterengine_gpu_dma_burst_calc (
  input  logic [7:0]  i_addr_word,
  input  logic [7:0]  i_offset_word,
  input  logic [31:0] i_remain,
  output logic [8:0]  o_burstlen
);
  logic [7:0] w_page_pos;
  logic [8:0] w_aligned;

  // Words left in the 1 KB page, clipped to the remaining transfer length.
  always_comb begin
    w_page_pos = i_addr_word + i_offset_word;
    w_aligned  = 9'd256 - {1'b0, w_page_pos};
    o_burstlen = (i_remain < {23'd0, w_aligned}) ? i_remain[8:0] : w_aligned;
  end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: fetches one channel's buffer and streams it to that channel's consumer.
module painterengine_gpu_dma_reader
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int PARAM_DATA_ALIGN = 32
) (
  input  logic                          i_wire_clock,
  input  logic                          i_wire_reset,
  input  logic [3:0]                    i_wire_router,
  input  logic [127:0]                  i_wire_address,
  input  logic [127:0]                  i_wire_length,
  output logic [4*PARAM_DATA_ALIGN-1:0] o_wire_data,
  output logic [3:0]                    o_wire_data_valid,
  input  logic [3:0]                    i_wire_data_next,
  output logic                          o_wire_done,
  output logic                          o_wire_error,
  output logic [2:0]                    o_wire_error_type,
  output logic                          o_wire_M_AXI_ARID,
  output logic [31:0]                   o_wire_M_AXI_ARADDR,
  output logic [7:0]                    o_wire_M_AXI_ARLEN,
  output logic [2:0]                    o_wire_M_AXI_ARSIZE,
  output logic [1:0]                    o_wire_M_AXI_ARBURST,
  output logic                          o_wire_M_AXI_ARLOCK,
  output logic [3:0]                    o_wire_M_AXI_ARCACHE,
  output logic [2:0]                    o_wire_M_AXI_ARPROT,
  output logic [3:0]                    o_wire_M_AXI_ARQOS,
  output logic                          o_wire_M_AXI_ARVALID,
  input  logic                          i_wire_M_AXI_ARREADY,
  input  logic                          i_wire_M_AXI_RID,
  input  logic [PARAM_DATA_ALIGN-1:0]   i_wire_M_AXI_RDATA,
  input  logic [1:0]                    i_wire_M_AXI_RRESP,
  input  logic                          i_wire_M_AXI_RLAST,
  input  logic                          i_wire_M_AXI_RVALID,
  output logic                          o_wire_M_AXI_RREADY
);

  dma_state_t  r_state, w_state_next;
  dma_err_t    r_err, w_err_next;
  logic [1:0]  r_idx;
  logic [31:0] r_addr, r_len, r_offset, r_araddr;
  logic [8:0]  r_burstlen, r_beat;
  logic [7:0]  r_arlen;
  logic        r_arvalid;
  logic [15:0] r_timeout, w_timeout_next;

  logic [1:0]  w_route_idx;
  logic [8:0]  w_burstlen, w_burst_m1;
  logic [31:0] w_offset_sum;
  logic        w_ar_hs, w_r_hs, w_last_beat, w_timeout_hit, w_rready;
  logic [3:0]  w_valid;
  logic        w_unused;

  assign w_unused      = i_wire_M_AXI_RID;
  assign w_route_idx   = onehot_to_index(i_wire_router);
  assign w_burst_m1    = w_burstlen - 9'd1;
  assign w_offset_sum  = r_offset + {23'd0, r_burstlen};
  assign w_ar_hs       = (r_state == ST_ADDR) && r_arvalid && i_wire_M_AXI_ARREADY;
  assign w_r_hs        = (r_state == ST_DATA) && i_wire_M_AXI_RVALID && i_wire_data_next[r_idx];
  assign w_last_beat   = (r_beat == (r_burstlen - 9'd1));
  assign w_timeout_hit = (r_timeout == TIMEOUT_LIMIT) &&
                         ((r_state == ST_ADDR) || (r_state == ST_DATA));

  painterengine_gpu_dma_burst_calc u_burst_calc (
    .i_addr_word   (r_addr[9:2]),
    .i_offset_word (r_offset[7:0]),
    .i_remain      (r_len - r_offset),
    .o_burstlen    (w_burstlen)
  );

  // Next-state, error code, timeout count and the combinational R-channel handshake.
  always_comb begin
    w_state_next   = r_state;
    w_err_next     = r_err;
    w_timeout_next = 16'd0;
    w_rready       = 1'b0;
    w_valid        = 4'd0;
    case (r_state)
      ST_ROUTING: begin
        if (is_onehot4(i_wire_router)) begin
          w_state_next = ST_PARAM_CHECK;
        end else begin
          w_state_next = ST_ERROR;
          w_err_next   = ERR_ROUTER;
        end
      end
      ST_PARAM_CHECK: begin
        if ((r_addr[1:0] != 2'd0) || (r_len == 32'd0)) begin
          w_state_next = ST_ERROR;
          w_err_next   = ERR_ADDRESS;
        end else begin
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: w_state_next = ST_ADDR;
      ST_ADDR: begin
        if (!i_wire_M_AXI_ARREADY) w_timeout_next = r_timeout + 16'd1;
        if (w_timeout_hit) begin
          w_state_next = ST_ERROR;
          w_err_next   = ERR_AR_TIMEOUT;
        end else if (w_ar_hs) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_rready        = i_wire_data_next[r_idx];
        w_valid[r_idx]  = i_wire_M_AXI_RVALID;
        if (!w_r_hs) w_timeout_next = r_timeout + 16'd1;
        if (w_timeout_hit) begin
          w_state_next = ST_ERROR;
          w_err_next   = ERR_DATA_TIMEOUT;
        end else if (w_r_hs) begin
          if (i_wire_M_AXI_RRESP[1]) begin
            w_state_next = ST_ERROR;
            w_err_next   = ERR_RESP;
          end else if (i_wire_M_AXI_RLAST != w_last_beat) begin
            w_state_next = ST_ERROR;
            w_err_next   = ERR_LAST;
          end else if (w_last_beat) begin
            w_state_next = (w_offset_sum >= r_len) ? ST_DONE : ST_CALC;
          end
        end
      end
      default: ;
    endcase
    if (w_state_next != r_state) w_timeout_next = 16'd0;
  end

  // State register and job datapath: channel latch, burst bookkeeping, AR request.
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      r_state    <= ST_ROUTING;
      r_err      <= ERR_OK;
      r_timeout  <= 16'd0;
      r_idx      <= 2'd0;
      r_addr     <= 32'd0;
      r_len      <= 32'd0;
      r_offset   <= 32'd0;
      r_burstlen <= 9'd0;
      r_beat     <= 9'd0;
      r_arvalid  <= 1'b0;
      r_araddr   <= 32'd0;
      r_arlen    <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_err     <= w_err_next;
      r_timeout <= w_timeout_next;
      case (r_state)
        ST_ROUTING: begin
          r_idx  <= w_route_idx;
          r_addr <= i_wire_address[w_route_idx*32 +: 32];
          r_len  <= i_wire_length[w_route_idx*32 +: 32];
        end
        ST_PARAM_CHECK: r_offset <= 32'd0;
        ST_CALC: begin
          r_burstlen <= w_burstlen;
          r_arvalid  <= 1'b1;
          r_araddr   <= r_addr + {r_offset[29:0], 2'b00};
          r_arlen    <= w_burst_m1[7:0];
        end
        ST_ADDR: begin
          if (w_timeout_hit || w_ar_hs) r_arvalid <= 1'b0;
          if (w_ar_hs) r_beat <= 9'd0;
        end
        ST_DATA: begin
          if (!w_timeout_hit && w_r_hs) begin
            if (w_last_beat) r_offset <= w_offset_sum;
            else             r_beat   <= r_beat + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data goes to the selected lane only.
  always_comb begin
    o_wire_data = '0;
    o_wire_data[r_idx*PARAM_DATA_ALIGN +: PARAM_DATA_ALIGN] = i_wire_M_AXI_RDATA;
  end

  assign o_wire_data_valid    = w_valid;
  assign o_wire_M_AXI_RREADY  = w_rready;
  assign o_wire_done          = (r_state == ST_DONE);
  assign o_wire_error         = (r_state == ST_ERROR);
  assign o_wire_error_type    = r_err;
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = r_araddr;
  assign o_wire_M_AXI_ARLEN   = r_arlen;
  assign o_wire_M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign o_wire_M_AXI_ARBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = AXI_CACHE_MOD;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = r_arvalid;

endmodule
